// File: rtl/vscalealu_pkg.sv
// Shared ALU opcodes and the combinational result function used by vscalealu_pipe.
// alu_compute works on 64-bit containers; narrower datapaths pass word=1 and keep the low bits.
package vscalealu_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

  // Word operands are sign-extended: low 32 bits of arithmetic are unchanged, and both
  // signed and unsigned ordering of the 32-bit values carry over to the 64-bit compare.
  function automatic logic [63:0] alu_compute(input logic [ALU_OP_WIDTH-1:0] op,
                                              input logic word,
                                              input logic [63:0] in1,
                                              input logic [63:0] in2);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [5:0]  sh;
    logic        is_cmp;
    logic        lt_s;
    logic        lt_u;
    a      = word ? {{32{in1[31]}}, in1[31:0]} : in1;
    b      = word ? {{32{in2[31]}}, in2[31:0]} : in2;
    sh     = word ? {1'b0, in2[4:0]} : in2[5:0];
    lt_s   = $signed(a) < $signed(b);
    lt_u   = a < b;
    r      = '0;
    is_cmp = 1'b0;
    case (op)
      ALU_OP_ADD:  r = a + b;
      ALU_OP_SUB:  r = a - b;
      ALU_OP_SLL:  r = a << sh;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_AND:  r = a & b;
      ALU_OP_SRL:  r = word ? ({32'b0, a[31:0]} >> sh) : (a >> sh);
      ALU_OP_SRA:  r = $signed(a) >>> sh;
      ALU_OP_SEQ:  begin is_cmp = 1'b1; r = {63'b0, a == b}; end
      ALU_OP_SNE:  begin is_cmp = 1'b1; r = {63'b0, a != b}; end
      ALU_OP_SLT:  begin is_cmp = 1'b1; r = {63'b0, lt_s};   end
      ALU_OP_SGE:  begin is_cmp = 1'b1; r = {63'b0, !lt_s};  end
      ALU_OP_SLTU: begin is_cmp = 1'b1; r = {63'b0, lt_u};   end
      ALU_OP_SGEU: begin is_cmp = 1'b1; r = {63'b0, !lt_u};  end
      default:     r = '0;
    endcase
    if (word && !is_cmp) begin
      r = {{32{r[31]}}, r[31:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/vscalealu_pipe_stage.sv
// One valid/ready register slice; accepts new data when empty or when its contents leave
// this cycle, so bubbles collapse and the slice holds steady under backpressure.
module vscalealu_pipe_stage #(
  parameter int WIDTH = 68
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/vscalealu_pipe.sv
// Pipelined handshaked ALU: result computed at the input, then carried through STAGES
// register slices together with the op's tag. In-order, one op per cycle sustained.
module vscalealu_pipe
  import vscalealu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int SHAMT_WIDTH = 6,
  parameter int STAGES      = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [ALU_OP_WIDTH-1:0] din_mode,
  input  logic                    din_word,
  input  logic [TAG_WIDTH-1:0]    din_tag,
  input  logic [XLEN-1:0]         din_arg1,
  input  logic [XLEN-1:0]         din_arg2,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [XLEN-1:0]         dout_result,
  output logic [TAG_WIDTH-1:0]    dout_tag
);

  localparam int PW = XLEN + TAG_WIDTH;
  // A 5-bit shift amount means a 32-bit datapath, which behaves exactly like word mode.
  localparam bit NARROW = (SHAMT_WIDTH == 5);

  logic [63:0]   arg1_ext;
  logic [63:0]   arg2_ext;
  logic [63:0]   res64;
  logic          word_eff;
  logic          ready_chain [STAGES+1];
  logic          valid_chain [STAGES+1];
  logic [PW-1:0] data_chain  [STAGES+1];

  always_comb begin
    arg1_ext = 64'(din_arg1);
    arg2_ext = 64'(din_arg2);
    word_eff = NARROW ? 1'b1 : din_word;
    res64    = alu_compute(din_mode, word_eff, arg1_ext, arg2_ext);
  end

  assign valid_chain[0]      = din_valid;
  assign data_chain[0]       = {din_tag, res64[XLEN-1:0]};
  assign ready_chain[STAGES] = dout_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    vscalealu_pipe_stage #(.WIDTH(PW)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (valid_chain[i]),
      .in_ready  (ready_chain[i]),
      .in_data   (data_chain[i]),
      .out_valid (valid_chain[i+1]),
      .out_ready (ready_chain[i+1]),
      .out_data  (data_chain[i+1])
    );
  end

  assign din_ready                 = !reset && ready_chain[0];
  assign dout_valid                = valid_chain[STAGES];
  assign {dout_tag, dout_result}   = data_chain[STAGES];

endmodule
